// File: rtl/dvp_rx_capture.sv
// DVP UYVY capture: pairs chroma/luma bytes into pixels, frames them with sof/eol/eof and checks
// line/frame geometry. Define DVP_RX_STATS_EN to add the line_width/frame_lines measurement outputs.
module dvp_rx_capture #(
   parameter int WDT = 64,
   parameter int HGT = 48,
   parameter int D   = 8
) (
   input  logic         pclk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         vsync,
   input  logic         href,
   input  logic [D-1:0] din,
   output logic         pix_valid,
   output logic [D-1:0] y_out,
   output logic [D-1:0] c_out,
   output logic         c_sel,
   output logic         sof,
   output logic         eol,
   output logic         eof,
   output logic         err_width,
   output logic         err_height
`ifdef DVP_RX_STATS_EN
   ,
   output logic [$clog2(WDT+1):0] line_width,
   output logic [$clog2(HGT+1):0] frame_lines
`endif
);
   localparam int PW = $clog2(WDT + 1);
   localparam int LW = $clog2(HGT + 1);
   localparam logic [PW-1:0] PIX_MAX   = PW'(WDT);
   localparam logic [PW-1:0] PIX_LAST  = PW'(WDT - 1);
   localparam logic [LW-1:0] LINE_MAX  = LW'(HGT);
   localparam logic [LW-1:0] LINE_LAST = LW'(HGT - 1);

   typedef enum logic [0:0] {S_SYNC = 1'b0, S_FRAME = 1'b1} state_t;
   state_t state_r, state_nxt_s;

   logic          vs_q, hr_q, vs_d_r, hr_d_r;
   logic [D-1:0]  d_q, chroma_r;
   logic          phase_r, csel_r, sof_arm_r, chk_r, pix_over_r, line_over_r;
   logic [PW-1:0] pix_cnt_r, pix_inc_s;
   logic [LW-1:0] line_cnt_r, line_inc_s, line_end_s;
   logic          vs_rise_s, hr_fall_s, cap_s, enter_s, emit_s, line_bad_s;

   // Pin registers plus one-cycle-delayed copies for edge detection
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q   <= 1'b0;
         hr_q   <= 1'b0;
         d_q    <= {D{1'b0}};
         vs_d_r <= 1'b0;
         hr_d_r <= 1'b0;
      end else begin
         vs_q   <= vsync;
         hr_q   <= href;
         d_q    <= din;
         vs_d_r <= vs_q;
         hr_d_r <= hr_q;
      end
   end

   // State register
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) state_r <= S_SYNC;
      else        state_r <= state_nxt_s;
   end

   // Edge decode, saturating increments and next state
   always_comb begin
      vs_rise_s   = vs_q & ~vs_d_r;
      hr_fall_s   = hr_d_r & ~hr_q;
      cap_s       = (state_r == S_FRAME) && en;
      enter_s     = (state_r == S_SYNC) && en && vs_rise_s;
      emit_s      = cap_s && hr_q && phase_r;
      pix_inc_s   = (pix_cnt_r == PIX_MAX) ? PIX_MAX : pix_cnt_r + PW'(1);
      line_inc_s  = (line_cnt_r == LINE_MAX) ? LINE_MAX : line_cnt_r + LW'(1);
      line_end_s  = hr_fall_s ? line_inc_s : line_cnt_r;
      // Saturated counters cannot tell HGT from HGT+n, so overflow is tracked separately
      line_bad_s  = (line_end_s != LINE_MAX) || line_over_r ||
                    (hr_fall_s && (line_cnt_r == LINE_MAX));
      state_nxt_s = state_r;
      case (state_r)
         S_SYNC: begin
            if (enter_s) state_nxt_s = S_FRAME;
            else         state_nxt_s = S_SYNC;
         end
         S_FRAME: begin
            if (!en) state_nxt_s = S_SYNC;
            else     state_nxt_s = S_FRAME;
         end
         default: state_nxt_s = S_SYNC;
      endcase
   end

   // Byte pairing, counters and registered outputs
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid   <= 1'b0;
         y_out       <= {D{1'b0}};
         c_out       <= {D{1'b0}};
         c_sel       <= 1'b0;
         sof         <= 1'b0;
         eol         <= 1'b0;
         eof         <= 1'b0;
         err_width   <= 1'b0;
         err_height  <= 1'b0;
         chroma_r    <= {D{1'b0}};
         phase_r     <= 1'b0;
         csel_r      <= 1'b0;
         sof_arm_r   <= 1'b0;
         chk_r       <= 1'b0;
         pix_over_r  <= 1'b0;
         line_over_r <= 1'b0;
         pix_cnt_r   <= {PW{1'b0}};
         line_cnt_r  <= {LW{1'b0}};
      end else begin
         pix_valid  <= 1'b0;
         sof        <= 1'b0;
         eol        <= 1'b0;
         eof        <= 1'b0;
         err_width  <= 1'b0;
         err_height <= 1'b0;
         if (!cap_s) begin
            phase_r     <= 1'b0;
            csel_r      <= 1'b0;
            chk_r       <= 1'b0;
            pix_over_r  <= 1'b0;
            line_over_r <= 1'b0;
            pix_cnt_r   <= {PW{1'b0}};
            line_cnt_r  <= {LW{1'b0}};
            sof_arm_r   <= enter_s;
         end else begin
            phase_r <= hr_q ? ~phase_r : 1'b0;
            if (hr_q && !phase_r) chroma_r <= d_q;
            if (emit_s) begin
               pix_valid <= 1'b1;
               y_out     <= d_q;
               c_out     <= chroma_r;
               c_sel     <= csel_r;
               sof       <= sof_arm_r;
               sof_arm_r <= 1'b0;
               eol       <= (pix_cnt_r == PIX_LAST);
               eof       <= (pix_cnt_r == PIX_LAST) && (line_cnt_r == LINE_LAST);
               csel_r    <= ~csel_r;
               pix_cnt_r <= pix_inc_s;
               if (pix_cnt_r == PIX_MAX) pix_over_r <= 1'b1;
            end
            if (hr_fall_s) begin
               err_width  <= (pix_cnt_r != PIX_MAX) || pix_over_r || phase_r;
               line_cnt_r <= line_inc_s;
               if (line_cnt_r == LINE_MAX) line_over_r <= 1'b1;
               pix_cnt_r  <= {PW{1'b0}};
               pix_over_r <= 1'b0;
               csel_r     <= 1'b0;
            end
            // Frame restart wins over the line close evaluated above on the same edge
            if (vs_rise_s) begin
               err_height  <= chk_r && line_bad_s;
               chk_r       <= 1'b1;
               sof_arm_r   <= 1'b1;
               line_cnt_r  <= {LW{1'b0}};
               line_over_r <= 1'b0;
               pix_cnt_r   <= {PW{1'b0}};
               pix_over_r  <= 1'b0;
               csel_r      <= 1'b0;
            end
         end
      end
   end

`ifdef DVP_RX_STATS_EN
   logic [PW:0] pix_raw_r;
   logic [LW:0] line_raw_r;

   // Unsaturated line/frame measurement
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         pix_raw_r   <= {(PW+1){1'b0}};
         line_raw_r  <= {(LW+1){1'b0}};
         line_width  <= {(PW+1){1'b0}};
         frame_lines <= {(LW+1){1'b0}};
      end else if (!cap_s) begin
         pix_raw_r  <= {(PW+1){1'b0}};
         line_raw_r <= {(LW+1){1'b0}};
      end else begin
         if (emit_s) pix_raw_r <= pix_raw_r + (PW+1)'(1);
         if (hr_fall_s) begin
            line_width <= pix_raw_r;
            pix_raw_r  <= {(PW+1){1'b0}};
            line_raw_r <= line_raw_r + (LW+1)'(1);
         end
         if (vs_rise_s) begin
            frame_lines <= hr_fall_s ? line_raw_r + (LW+1)'(1) : line_raw_r;
            line_raw_r  <= {(LW+1){1'b0}};
            pix_raw_r   <= {(PW+1){1'b0}};
         end
      end
   end
`endif

endmodule

// File: tb/tb_dvp_rx_capture.sv
// Bench for dvp_rx_capture (WDT=4, HGT=2): vector table for a clean frame, hand-written corner
// sequences and randomized frames checked against a line/frame-level reference model.
module tb_dvp_rx_capture;
   localparam int WDT = 4;
   localparam int HGT = 2;
   localparam int D   = 8;

   logic       pclk  = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b0;
   logic       vsync = 1'b0;
   logic       href  = 1'b0;
   logic [7:0] din   = 8'h00;
   logic       pix_valid, c_sel, sof, eol, eof, err_width, err_height;
   logic [7:0] y_out, c_out;
`ifdef DVP_RX_STATS_EN
   logic [$clog2(WDT+1):0] line_width;
   logic [$clog2(HGT+1):0] frame_lines;
`endif

   dvp_rx_capture #(.WDT(WDT), .HGT(HGT), .D(D)) dut (
      .pclk(pclk), .rst_n(rst_n), .en(en), .vsync(vsync), .href(href), .din(din),
      .pix_valid(pix_valid), .y_out(y_out), .c_out(c_out), .c_sel(c_sel),
      .sof(sof), .eol(eol), .eof(eof), .err_width(err_width), .err_height(err_height)
`ifdef DVP_RX_STATS_EN
      , .line_width(line_width), .frame_lines(frame_lines)
`endif
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic [7:0] y;
      logic [7:0] c;
      logic cs, so, el, ef;
   } pix_t;

   typedef struct packed {
      logic vs, hr;
      logic [7:0] d;
      logic pv;
      logic [7:0] y, c;
      logic cs, so, el, ef, ew, eh;
   } vec_t;

   int   n_pass = 0, n_tot = 0;
   int   edge_n = 0, ew_edge = -1, ew_cnt = 0, eh_cnt = 0, b2b_cnt = 0, fall_edge = 0;
   int   exp_ew = 0, exp_eh = 0;
   logic prev_pv = 1'b0;
   pix_t got_q[$], exp_q[$];
   pix_t mon_p;
   vec_t tv[24];

   // reference model state: capturing, frame already checked once, lines so far, sof pending
   int m_active = 0, m_checked = 0, m_lines = 0, m_sof = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(posedge pclk) edge_n <= edge_n + 1;

   always @(negedge pclk) begin
      if (pix_valid) begin
         mon_p = {y_out, c_out, c_sel, sof, eol, eof};
         got_q.push_back(mon_p);
      end
      if (pix_valid && prev_pv) b2b_cnt++;
      if (err_width) begin
         ew_cnt++;
         ew_edge = edge_n;
      end
      if (err_height) eh_cnt++;
      prev_pv = pix_valid;
   end

   task automatic step(input logic vs, input logic hr, input logic [7:0] d);
      vsync = vs;
      href  = hr;
      din   = d;
      @(posedge pclk);
      #1;
   endtask

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      ew_cnt = 0;
      eh_cnt = 0;
      exp_ew = 0;
      exp_eh = 0;
   endtask

   // Drive one line of nb random bytes, then gap idle cycles; predict its pixels and errors
   task automatic send_line(input int nb, input int gap);
      logic [7:0] b[$];
      pix_t p;
      for (int i = 0; i < nb; i++) begin
         b.push_back(8'($urandom_range(0, 255)));
         step(1'b0, 1'b1, b[i]);
      end
      step(1'b0, 1'b0, 8'h00);
      fall_edge = edge_n;
      for (int i = 1; i < gap; i++) step(1'b0, 1'b0, 8'h00);
      if (m_active != 0) begin
         for (int k = 0; k < nb / 2; k++) begin
            p.y  = b[2*k+1];
            p.c  = b[2*k];
            p.cs = ((k % 2) == 1);
            p.so = (m_sof != 0) && (k == 0);
            p.el = (k == WDT - 1);
            p.ef = (k == WDT - 1) && (m_lines == HGT - 1);
            exp_q.push_back(p);
         end
         if (nb >= 2) m_sof = 0;
         if (nb != 2 * WDT) exp_ew++;
         m_lines++;
      end
   endtask

   task automatic send_vsync();
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      if (m_active != 0) begin
         if ((m_checked != 0) && (m_lines != HGT)) exp_eh++;
         m_checked = 1;
      end else if (en) begin
         m_active  = 1;
         m_checked = 0;
      end
      m_lines = 0;
      m_sof   = 1;
   endtask

   task automatic compare(input string tag);
      chk({tag, "_npix"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
      chk({tag, "_err_width"}, ew_cnt, exp_ew);
      chk({tag, "_err_height"}, eh_cnt, exp_eh);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] bb[10];
      pix_t p;
      int   f7;

      // clean frame, UYVY bytes 80,11,80,22,... : one vsync, two 8-byte lines
      for (int i = 0; i < 24; i++) tv[i] = '0;
      tv[0].vs = 1'b1;
      for (int l = 0; l < 2; l++) begin
         for (int b = 0; b < 8; b++) begin
            tv[3+10*l+b].hr = 1'b1;
            tv[3+10*l+b].d  = ((b % 2) == 0) ? 8'h80 : 8'(17 * (4*l + b/2 + 1));
         end
         for (int q = 0; q < 4; q++) begin
            tv[5+10*l+2*q].pv = 1'b1;
            tv[5+10*l+2*q].y  = 8'(17 * (4*l + q + 1));
            tv[5+10*l+2*q].c  = 8'h80;
            tv[5+10*l+2*q].cs = ((q % 2) == 1);
            tv[5+10*l+2*q].so = (l == 0) && (q == 0);
            tv[5+10*l+2*q].el = (q == 3);
            tv[5+10*l+2*q].ef = (q == 3) && (l == 1);
         end
      end

      repeat (3) @(posedge pclk);
      #1;
      chk("reset_state", {pix_valid, y_out, c_out, c_sel, sof, eol, eof, err_width, err_height}, 64'd0);
      rst_n = 1'b1;
      en    = 1'b1;
      step(1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 24; i++) begin
         step(tv[i].vs, tv[i].hr, tv[i].d);
         if (tv[i].pv)
            chk($sformatf("table_%0d", i),
                {pix_valid, y_out, c_out, c_sel, sof, eol, eof, err_width, err_height},
                {tv[i].pv, tv[i].y, tv[i].c, tv[i].cs, tv[i].so, tv[i].el, tv[i].ef, tv[i].ew, tv[i].eh});
         else
            chk($sformatf("table_%0d", i), {pix_valid, sof, eol, eof, err_width, err_height},
                {tv[i].pv, tv[i].so, tv[i].el, tv[i].ef, tv[i].ew, tv[i].eh});
      end
      m_active = 1; m_checked = 0; m_lines = 2; m_sof = 0;

      // 7-byte line then a normal one; closing vsync is the first in-frame one: no err_height
      clear_mon();
      send_line(7, 2);
      f7 = fall_edge;
      send_line(8, 2);
      chk("err_width_timing", ew_edge, f7 + 1);
      send_vsync();
      compare("odd_line");

      // three-line frame must flag err_height once
      clear_mon();
      send_line(8, 2); send_line(8, 2); send_line(8, 2);
      send_vsync();
      compare("three_lines");

      // randomized frames: line lengths around WDT (odd, short, long), 1..3 lines per frame
      clear_mon();
      for (int f = 0; f < 6; f++) begin
         int nl;
         nl = $urandom_range(1, 3);
         for (int l = 0; l < nl; l++)
            send_line(($urandom_range(0, 2) == 0) ? 8 : $urandom_range(4, 11), $urandom_range(2, 3));
         send_vsync();
      end
      compare("random");

      // en dropped mid-line, restored later: silent until next vsync
      clear_mon();
      send_vsync();
      for (int i = 0; i < 10; i++) begin
         if (i == 5) en = 1'b0;
         if (i == 8) en = 1'b1;
         bb[i] = 8'($urandom_range(0, 255));
         step(1'b0, 1'b1, bb[i]);
      end
      for (int q = 0; q < 2; q++) begin
         p.y = bb[2*q+1]; p.c = bb[2*q]; p.cs = (q == 1); p.so = (q == 0); p.el = 1'b0; p.ef = 1'b0;
         exp_q.push_back(p);
      end
      m_active = 0; m_sof = 0;
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      send_line(8, 2);
      send_vsync();
      send_line(8, 2);
      compare("en_drop");

      // asynchronous reset mid-line clears outputs at once; resume only after vsync
      clear_mon();
      send_vsync();
      step(1'b0, 1'b1, 8'h80);
      step(1'b0, 1'b1, 8'hA1);
      step(1'b0, 1'b1, 8'h80);
      chk("pre_reset_pix", {pix_valid, y_out}, {1'b1, 8'hA1});
      #1 rst_n = 1'b0;
      #1;
      chk("reset_mid_line", {pix_valid, y_out, c_out, c_sel, sof, eol, eof, err_width, err_height}, 64'd0);
      step(1'b0, 1'b1, 8'hA2);
      rst_n = 1'b1;
      m_active = 0; m_checked = 0; m_lines = 0; m_sof = 0;
      step(1'b0, 1'b1, 8'h80);
      step(1'b0, 1'b1, 8'hA3);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      send_line(8, 2);
      send_vsync();
      send_line(8, 2);
      compare("reset");

`ifdef DVP_RX_STATS_EN
      clear_mon();
      send_line(10, 2);
      chk("stats_line_width", line_width, 64'd5);
      send_vsync();
      chk("stats_frame_lines", frame_lines, 64'd2);
      compare("stats");
`endif

      chk("no_back_to_back", b2b_cnt, 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/dvp_rx_capture.md
# dvp_rx_capture

Receive-side DVP capture block: samples the 8-bit UYVY byte stream produced by the camera interface (`pclk`/`vsync`/`href`/data), pairs chroma and luma bytes into one pixel per two bytes, and emits a framed pixel stream with start-of-frame, end-of-line and end-of-frame markers. It sits between the DVP pins (or the DVP source model in simulation) and the downstream image-processing pipeline. It also checks frame geometry against the configured `WDT`×`HGT` and flags violations.

## Interface
- `WDT`, 64, active pixels per line (one pixel = 2 bytes)
- `HGT`, 48, active lines per frame
- `D`, 8, DVP data width
- `pclk`  in  1  DVP pixel clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  capture enable
- `vsync`  in  1  frame sync, active high
- `href`  in  1  line-valid, active high
- `din`  in  D  DVP data byte, UYVY order
- `pix_valid`  out  1  pixel strobe, one `pclk` cycle per pixel
- `y_out`  out  D  luma of current pixel
- `c_out`  out  D  chroma byte (U or V) paired with `y_out`
- `c_sel`  out  1  0 = `c_out` is U, 1 = V (alternates per pixel, 0 at line start)
- `sof`, `eol`, `eof`  out  1 each  qualified by `pix_valid`: first pixel of frame, last pixel of line, last pixel of frame
- `err_width`  out  1  one-cycle pulse: line ended with pixel count ≠ `WDT` or odd byte count
- `err_height`  out  1  one-cycle pulse: frame ended with line count ≠ `HGT`

## Operation
- Input stage: `vsync`, `href`, `din` registered into `vs_q`, `hr_q`, `d_q` every edge; all decisions use the registered copies.
- FSM, 2 states:
  - `S_SYNC`: reset state. Discards all bytes. On `vs_q` rising edge (with `en`=1) → `S_FRAME`, clear line/pixel counters, arm `sof`.
  - `S_FRAME`: captures. On `vs_q` rising edge: evaluate `err_height` (line count ≠ `HGT`), clear counters, re-arm `sof`, stay. `en`=0 at any edge → `S_SYNC`; partial frame dropped, no error pulses.
- Byte phase: `phase` clears when `hr_q`=0; toggles on each byte with `hr_q`=1. Phase 0 byte latched as chroma; phase 1 byte forms pixel with held chroma.
- Pixel counter (width ⌈log2(WDT+1)⌉) increments per emitted pixel, saturates at `WDT`; extra pixels beyond `WDT` are still emitted (`eol` not repeated).
- `eol` when pixel count = `WDT`−1; `eof` when additionally line count = `HGT`−1. `sof` on first pixel after arming.
- `hr_q` falling edge: line counter +1 (saturating at `HGT`); `err_width` if pixel count ≠ `WDT` or `phase`=1 (orphan chroma byte dropped). Pixel counter and `c_sel` clear.
- `err_height` not evaluated on the first `vsync` after entering `S_FRAME`.

## Timing
- Reset: all outputs 0, FSM `S_SYNC`, counters 0, `phase` 0.
- Latency: luma byte present on `din` at edge N is registered into `d_q` at N; `pix_valid`/`y_out`/`c_out` registered at N+1, valid in cycle after N+1. Fixed 2-edge latency from pin to output.
- Min pixel spacing: 2 cycles; `pix_valid` never high on consecutive cycles.
- `err_width` asserts the cycle after `hr_q` falls; `err_height` the cycle after `vs_q` rises.
- `vsync` rising while `href` high: line closed first (`err_width` evaluated), then frame restart on same edge.
- `rst_n` low mid-line: immediate clear; resume requires next `vsync`.

## Configuration
- `DVP_RX_STATS_EN`: when defined, adds outputs `line_width` (⌈log2(WDT+1)⌉+1 bits, last measured pixels/line, unsaturated counter) and `frame_lines` (⌈log2(HGT+1)⌉+1 bits, last measured lines/frame), updated on `hr_q` fall / `vs_q` rise, reset 0. Undefined: ports absent, counters saturate as above, no measurement logic.

## Test plan
- `WDT`=4, `HGT`=2, clean frame bytes 80,11,80,22,…: 8 `pix_valid` pulses, `y_out` = 11,22,…, `c_out`=80, `c_sel` 0,1,0,1; `sof` on pixel 0, `eol` on pixels 3,7, `eof` on 7, no errors.
- Line with 7 bytes: 3 pixels, `err_width` pulse 1 cycle after `href` falls; next line normal.
- Frame with 3 lines then `vsync`: `err_height`=1 once; first frame after reset never flags `err_height`.
- `en` dropped mid-frame then restored: no output until next `vsync`, then `sof` on first pixel.
- `rst_n` pulsed low mid-line: all outputs 0 within same cycle; capture resumes only after next `vsync`.
- With `DVP_RX_STATS_EN`, 5-pixel line: `line_width`=5, `err_width`=1.
